// File: rtl/sobel_grad_pkg.sv
// Shared constants for the Sobel gradient stage.
// Kept free of width parameters so any instance size can import it.
package sobel_grad_pkg;

  // Extra bits over the pixel width that hold a worst-case 3x3 Sobel sum plus sign.
  localparam int unsigned GuardBits = 3;

endpackage

// File: rtl/sobel_line_buf.sv
// One-row line buffer: one write and one asynchronous read per cycle on the same column address.
// A read in the cycle of a write returns the old contents (read-before-write).
module sobel_line_buf #(
  parameter int unsigned depth_p  = 640,
  parameter int unsigned width_p  = 8,
  parameter int unsigned addr_w_p = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                clk,
  input  logic                we,
  input  logic [addr_w_p-1:0] addr,
  input  logic [width_p-1:0]  wdata,
  output logic [width_p-1:0]  rdata
);

  logic [width_p-1:0] mem [depth_p];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_grad.sv
// Streaming 3x3 Sobel stage: two line buffers feed a 3x3 window and emit
// registered signed gx/gy for every fully interior pixel position.
module sobel_grad
  import sobel_grad_pkg::*;
#(
  parameter int unsigned width_p     = 8,
  parameter int unsigned width_out_p = 16,
  parameter int unsigned cols_p      = 640,
  parameter int unsigned rows_p      = 480
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  input  logic [width_p-1:0]            pixel_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic signed [width_out_p-1:0] gx_o,
  output logic signed [width_out_p-1:0] gy_o,
  input  logic                          ready_i
);

  localparam int unsigned GradW = width_p + GuardBits;
  localparam int unsigned ColW  = (cols_p > 1) ? $clog2(cols_p) : 1;
  localparam int unsigned RowW  = (rows_p > 1) ? $clog2(rows_p) : 1;

  logic [ColW-1:0]             col_q, col_d;
  logic [RowW-1:0]             row_q, row_d;
  logic [width_p-1:0]          win_q [3][3];
  logic [width_p-1:0]          win_d [3][3];
  logic [width_p-1:0]          row1_px, row2_px;
  logic                        accept, complete;
  logic signed [GradW-1:0]     p [3][3];
  logic signed [GradW-1:0]     gx, gy;
  logic                        valid_q;
  logic signed [width_out_p-1:0] gx_q, gy_q;

  assign ready_o  = ~valid_q | ready_i;
  assign accept   = valid_i & ready_o;
  assign complete = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColW'(cols_p - 1)) begin
        col_d = '0;
        row_d = (row_q == RowW'(rows_p - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Window row 0 is the oldest image row; column 2 receives the newest pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = row2_px;
      win_d[1][2] = row1_px;
      win_d[2][2] = pixel_i;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) begin
        p[r][k] = signed'({{GuardBits{1'b0}}, win_d[r][k]});
      end
    end
    gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '{default: '0};
      valid_q <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
      if (accept && complete) begin
        valid_q <= 1'b1;
        gx_q    <= width_out_p'(gx);
        gy_q    <= width_out_p'(gy);
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  sobel_line_buf #(
    .depth_p  (cols_p),
    .width_p  (width_p),
    .addr_w_p (ColW)
  ) u_row1_buf (
    .clk   (clk_i),
    .we    (accept),
    .addr  (col_q),
    .wdata (pixel_i),
    .rdata (row1_px)
  );

  sobel_line_buf #(
    .depth_p  (cols_p),
    .width_p  (width_p),
    .addr_w_p (ColW)
  ) u_row2_buf (
    .clk   (clk_i),
    .we    (accept),
    .addr  (col_q),
    .wdata (row1_px),
    .rdata (row2_px)
  );

  assign valid_o = valid_q;
  assign gx_o    = gx_q;
  assign gy_o    = gy_q;

endmodule

// File: tb/tb_sobel_grad.sv
// Directed bench for sobel_grad on a 4x4 frame: known images with hand-computed gradients,
// stalls on both handshakes, back-to-back frames and a mid-frame reset.
module tb_sobel_grad;

  localparam int unsigned W    = 8;
  localparam int unsigned WO   = 16;
  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 4;

  logic                 clk;
  logic                 reset_i;
  logic                 valid_i;
  logic [W-1:0]         pixel_i;
  logic                 ready_o;
  logic                 valid_o;
  logic signed [WO-1:0] gx_o;
  logic signed [WO-1:0] gy_o;
  logic                 ready_i;

  typedef struct {
    int gx;
    int gy;
  } res_t;

  res_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hold_err = 0;
  bit   prev_stall = 0;
  int   prev_gx = 0;
  int   prev_gy = 0;

  sobel_grad #(
    .width_p     (W),
    .width_out_p (WO),
    .cols_p      (COLS),
    .rows_p      (ROWS)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .pixel_i (pixel_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .gx_o    (gx_o),
    .gy_o    (gy_o),
    .ready_i (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer and verify the register holds while stalled.
  always @(negedge clk) begin
    res_t r;
    if (prev_stall) begin
      if (!valid_o || int'(gx_o) != prev_gx || int'(gy_o) != prev_gy) hold_err++;
    end
    prev_stall = valid_o && !ready_i;
    prev_gx    = int'(gx_o);
    prev_gy    = int'(gy_o);
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      r.gx = int'(gx_o);
      r.gy = int'(gy_o);
      q.push_back(r);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix_of(input int kind, input int r, input int c);
    case (kind)
      0:       return 100;
      1:       return 10 * c;
      2:       return 10 * r;
      3:       return (c == 0) ? 0 : 255;
      5:       return (c == 0) ? 255 : 0;
      default: return r * 4 + c;
    endcase
  endfunction

  task automatic send_pixel(input int pix, input bit stall);
    int gap;
    bit acc;
    int t;
    gap = stall ? int'($urandom_range(0, 2)) : 0;
    repeat (gap) begin
      valid_i = 1'b0;
      ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b1;
    pixel_i = pix[W-1:0];
    acc = 1'b0;
    t = 0;
    while (!acc && t < 200) begin
      ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      t++;
    end
    valid_i = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $error("FAIL accept_timeout: observed no accept, expected accept within 200 cycles");
    end
  endtask

  task automatic send_frame(input int kind, input bit stall);
    for (int r = 0; r < int'(ROWS); r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        send_pixel(pix_of(kind, r, c), stall);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int g0, input int g1, input int g2,
                             input int g3, input int gy_exp);
    int exp_gx [4];
    int ogx;
    int ogy;
    exp_gx = '{g0, g1, g2, g3};
    check({tag, " count"}, q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      ogx = (i < q.size()) ? q[i].gx : 'h7fffffff;
      ogy = (i < q.size()) ? q[i].gy : 'h7fffffff;
      check($sformatf("%s gx[%0d]", tag, i), ogx, exp_gx[i]);
      check($sformatf("%s gy[%0d]", tag, i), ogy, gy_exp);
    end
    q.delete();
  endtask

  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    pixel_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("reset valid_o", int'(valid_o), 0);
    check("reset gx_o", int'(gx_o), 0);
    check("reset gy_o", int'(gy_o), 0);
    check("reset ready_o", int'(ready_o), 1);
    @(posedge clk);
    #1;
    q.delete();

    send_frame(0, 1'b0);
    check_frame("const100", 0, 0, 0, 0, 0);

    send_frame(1, 1'b0);
    check_frame("hramp", 80, 80, 80, 80, 0);

    send_frame(2, 1'b0);
    check_frame("vramp", 0, 0, 0, 0, 80);

    send_frame(3, 1'b0);
    check_frame("edge_pos", 1020, 0, 1020, 0, 0);

    send_frame(5, 1'b0);
    check_frame("edge_neg", -1020, 0, -1020, 0, 0);

    // Pixel = 4*row + col: horizontal step 1, vertical step 4.
    hold_err = 0;
    send_frame(4, 1'b1);
    check_frame("stall_ramp", 8, 8, 8, 8, 32);
    check("stall hold", hold_err, 0);

    // Eleven pixels reach row 2 col 2; hold the result, then reset mid-frame.
    for (int i = 0; i < 11; i++) begin
      send_pixel(pix_of(4, i / 4, i % 4), 1'b0);
    end
    ready_i = 1'b0;
    check("latency valid_o", int'(valid_o), 1);
    check("latency gx_o", int'(gx_o), 8);
    check("latency gy_o", int'(gy_o), 32);
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    check("midreset valid_o", int'(valid_o), 0);
    check("midreset gx_o", int'(gx_o), 0);
    check("midreset gy_o", int'(gy_o), 0);
    check("midreset ready_o", int'(ready_o), 1);
    ready_i = 1'b1;
    q.delete();
    send_frame(2, 1'b0);
    check_frame("post_reset", 0, 0, 0, 0, 80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
